// File: rtl/jam_pkg.sv
// Shared constants and state type for the JAM cost-matrix server.
package jam_pkg;
  localparam int unsigned N_WORKER   = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned COST_W_DEF = 7;
  localparam int unsigned MAT_SIZE   = 64;
  localparam int unsigned ADDR_W     = 2 * IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } jam_srv_state_t;
endpackage

// File: rtl/cost_ram_8x8.sv
// 64-entry cost storage: one synchronous write port, one registered read port
// (read-before-write). Only the read register is reset; the array is not.
module cost_ram_8x8
  import jam_pkg::*;
#(
  parameter int unsigned COST_W = COST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COST_W-1:0] rdata
);
  logic [COST_W-1:0] mem [MAT_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/jam_cost_server.sv
// Loads an 8x8 cost matrix over valid/ready, holds JAM in reset while loading,
// then serves registered Cost lookups. Optional checksum port: JAM_COST_CHECKSUM_EN.
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int unsigned COST_W = COST_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COST_W-1:0] in_data,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              jam_valid,
  output logic              jam_rst,
  output logic              loaded
`ifdef JAM_COST_CHECKSUM_EN
  , output logic [12:0]     checksum
`endif
);
  jam_srv_state_t    state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              hs;
  logic              last_beat;

  assign in_ready  = !RST && (state != RUN);
  assign hs        = in_valid && in_ready;
  assign last_beat = (addr == ADDR_W'(MAT_SIZE - 1));
  assign jam_rst   = RST || (state == IDLE) || (state == LOAD);
  assign loaded    = !RST && ((state == RUN) || (state == DONE));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      if (hs) addr <= addr + ADDR_W'(1);
    end
  end

  // addr is 0 whenever a load starts from IDLE or DONE, so one test covers all loading states
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD, DONE: if (hs) state_nxt = last_beat ? RUN : LOAD;
      RUN:              if (jam_valid) state_nxt = DONE;
      default:          state_nxt = IDLE;
    endcase
  end

`ifdef JAM_COST_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (RST)                checksum <= '0;
    else if (hs) begin
      if (state != LOAD)    checksum <= 13'(in_data);
      else                  checksum <= checksum + 13'(in_data);
    end
  end
`endif

  cost_ram_8x8 #(.COST_W(COST_W)) u_ram (
    .clk   (CLK),
    .rst   (RST),
    .we    (hs),
    .waddr (addr),
    .wdata (in_data),
    .raddr ({W, J}),
    .rdata (Cost)
  );
endmodule

// File: tb/tb_jam_cost_server.sv
// Directed self-checking bench for jam_cost_server (checksum checks when JAM_COST_CHECKSUM_EN).
module tb_jam_cost_server;
  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic [2:0] W, J;
  logic [6:0] Cost;
  logic       jam_valid;
  logic       jam_rst;
  logic       loaded;
`ifdef JAM_COST_CHECKSUM_EN
  logic [12:0] checksum;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  jam_cost_server #(.COST_W(7)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .W         (W),
    .J         (J),
    .Cost      (Cost),
    .jam_valid (jam_valid),
    .jam_rst   (jam_rst),
    .loaded    (loaded)
`ifdef JAM_COST_CHECKSUM_EN
    , .checksum (checksum)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(input logic [6:0] val);
    in_valid = 1'b1;
    in_data  = val;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int unsigned idx, input logic [6:0] exp);
    W = 3'(idx / 8);
    J = 3'(idx % 8);
    tick();
    check_eq(tag, 32'(Cost), 32'(exp));
  endtask

  task automatic pulse_jam_valid();
    jam_valid = 1'b1;
    tick();
    jam_valid = 1'b0;
  endtask

  initial begin
    int unsigned cnt;
    int unsigned budget;
    RST = 1'b1; in_valid = 1'b0; in_data = '0; W = '0; J = '0; jam_valid = 1'b0;
    tick(); tick();
    check_eq("rst_in_ready", 32'(in_ready), 0);
    check_eq("rst_jam_rst",  32'(jam_rst), 1);
    check_eq("rst_cost",     32'(Cost), 0);
    check_eq("rst_loaded",   32'(loaded), 0);
`ifdef JAM_COST_CHECKSUM_EN
    check_eq("rst_checksum", 32'(checksum), 0);
`endif
    RST = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 1);

    // Load k = 0..63
    for (int k = 0; k < 63; k++) beat(7'(k));
    check_eq("load63_jam_rst", 32'(jam_rst), 1);
    check_eq("load63_loaded",  32'(loaded), 0);
    beat(7'd63);
    check_eq("run_jam_rst",  32'(jam_rst), 0);
    check_eq("run_loaded",   32'(loaded), 1);
    check_eq("run_in_ready", 32'(in_ready), 0);
    read_chk("cost_w3_j5", 29, 7'd29);
`ifdef JAM_COST_CHECKSUM_EN
    check_eq("checksum_ramp", 32'(checksum), 2016);
`endif

    // Beats offered during RUN must be ignored
    in_valid = 1'b1; in_data = 7'd127;
    for (int i = 0; i < 5; i++) tick();
    check_eq("run_hold_in_ready", 32'(in_ready), 0);
    check_eq("run_hold_loaded",   32'(loaded), 1);
    in_valid = 1'b0;
    read_chk("cost_w0_j0_run", 0, 7'd0);
    for (int k = 0; k < 64; k++) read_chk("ramp_entry", k, 7'(k));

    pulse_jam_valid();
    check_eq("done_in_ready", 32'(in_ready), 1);
    check_eq("done_jam_rst",  32'(jam_rst), 0);
    check_eq("done_loaded",   32'(loaded), 1);
    // jam_valid in DONE has no effect
    pulse_jam_valid();
    check_eq("done_hold_loaded", 32'(loaded), 1);

    beat(7'd99);
    check_eq("reload_jam_rst", 32'(jam_rst), 1);
    check_eq("reload_loaded",  32'(loaded), 0);
`ifdef JAM_COST_CHECKSUM_EN
    check_eq("checksum_first_beat", 32'(checksum), 99);
`endif
    read_chk("mem0_new", 0, 7'd99);
    read_chk("mem1_old", 1, 7'd1);

    // Partial load of 30 beats then reset mid-load
    for (int k = 1; k < 30; k++) beat(7'd50);
    pulse_jam_valid();
    check_eq("load_ignores_jam_valid", 32'(jam_rst), 1);
    RST = 1'b1;
    #1;
    check_eq("midrst_in_ready", 32'(in_ready), 0);
    tick();
    check_eq("midrst_jam_rst", 32'(jam_rst), 1);
    RST = 1'b0;
    for (int k = 0; k < 63; k++) beat(7'd7);
    check_eq("sevens63_loaded", 32'(loaded), 0);
    beat(7'd7);
    check_eq("sevens64_loaded", 32'(loaded), 1);
    for (int k = 0; k < 64; k++) read_chk("sevens_entry", k, 7'd7);
`ifdef JAM_COST_CHECKSUM_EN
    check_eq("checksum_sevens", 32'(checksum), 448);
`endif

    pulse_jam_valid();
    for (int k = 0; k < 64; k++) beat(7'd127);
    check_eq("max_loaded", 32'(loaded), 1);
    read_chk("max_entry", 63, 7'd127);
`ifdef JAM_COST_CHECKSUM_EN
    check_eq("checksum_max", 32'(checksum), 8128);
`endif
    pulse_jam_valid();
    for (int k = 0; k < 64; k++) beat(7'd1);
    read_chk("ones_entry", 40, 7'd1);
`ifdef JAM_COST_CHECKSUM_EN
    check_eq("checksum_ones", 32'(checksum), 64);
`endif

    // Gappy load: values k+10, transition must follow exactly the 64th handshake
    pulse_jam_valid();
    cnt = 0;
    budget = 0;
    while (cnt < 64 && budget < 1000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 7'(cnt + 10);
      tick();
      if (in_valid) begin
        cnt++;
        if (cnt == 63) check_eq("gap63_loaded", 32'(loaded), 0);
        if (cnt == 64) check_eq("gap64_loaded", 32'(loaded), 1);
      end
      budget++;
    end
    in_valid = 1'b0;
    check_eq("gap_handshakes", 32'(cnt), 64);
    for (int k = 0; k < 64; k++) read_chk("gap_entry", k, 7'(k + 10));
`ifdef JAM_COST_CHECKSUM_EN
    check_eq("checksum_gap", 32'(checksum), 2656);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/jam_cost_server.md
# jam_cost_server

Upstream cost-matrix server for the JAM job-assignment engine. Accepts a 64-entry, 8x8 cost matrix over a valid/ready stream in row-major order and holds JAM in reset while loading. Once loaded, it releases JAM and answers JAM's worker/job (W, J) lookups with a registered Cost one cycle later. When JAM raises Valid, it returns to accepting the next matrix.

## Interface
Parameters:
- COST_W, 7, cost entry width; matches JAM's Cost input.

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- in_valid  in  1  load-stream beat valid.
- in_ready  out  1  load-stream ready.
- in_data  in  COST_W  cost entry, row-major: beat k is worker k/8, job k%8.
- W  in  3  worker index driven by JAM.
- J  in  3  job index driven by JAM.
- Cost  out  COST_W  registered cost for the previous cycle's {W, J}.
- jam_valid  in  1  JAM's Valid (search finished).
- jam_rst  out  1  reset to JAM; high while no complete matrix is loaded.
- loaded  out  1  high in RUN and DONE.

## Operation
- States:
  - IDLE: after reset.
  - LOAD: partial matrix received.
  - RUN: matrix complete, JAM released.
  - DONE: JAM reported Valid.
- Handshake: a beat transfers on a cycle where in_valid and in_ready are both high. in_valid while in_ready is low is ignored, with no side effects.
- in_ready is 1 in IDLE, LOAD and DONE. It is 0 in RUN and during any cycle with RST high.
- 6-bit write address counter:
  - Each handshake writes in_data to mem[addr], then addr increments.
  - addr wraps 63 -> 0 on the 64th beat.
- Transitions:
  - IDLE -> LOAD on the first handshake, unless that beat is the 64th.
  - DONE -> LOAD on the first handshake; that beat writes address 0 and jam_rst reasserts.
  - LOAD -> RUN on the handshake with addr == 63.
  - RUN -> DONE when jam_valid == 1.
  - jam_valid is ignored in every state other than RUN.
- jam_rst = 1 in IDLE and LOAD, 0 in RUN and DONE. In DONE it stays low so JAM holds MinCost, MatchCount and Valid.
- Lookup: Cost <= mem[{W, J}] every cycle, in every state.
  - A same-cycle write to the same address returns the old data (read-before-write).
- Storage is not reset; Cost is reset.
- Reset mid-operation: returns to IDLE, addr = 0, and the partial matrix is discarded. The next load starts at worker 0, job 0.

## Timing
- Reset values: in_ready 0, jam_rst 1, Cost 0, loaded 0, state IDLE, addr 0, checksum 0.
- in_ready rises in the first cycle after RST deasserts.
- Load throughput: one beat per cycle; 64 cycles minimum.
- 64th handshake in cycle t: in cycle t+1, state is RUN, jam_rst = 0, loaded = 1, in_ready = 0.
- Read latency: exactly 1 cycle. {W, J} sampled at edge t gives Cost valid after edge t. This matches JAM's registered W/J with delayed capture.
- jam_valid high in cycle t while in RUN: in cycle t+1, state is DONE and in_ready = 1.

## Configuration
- JAM_COST_CHECKSUM_EN defined:
  - Adds output checksum [12:0], the unsigned sum of all accepted beats of the current matrix. The maximum is 64*127 = 8128, so it cannot overflow.
  - checksum clears on reset and on the first beat of each new load. That first beat's clear and add happen in the same cycle, so checksum equals that beat's value.
  - checksum is frozen in RUN and DONE.
- JAM_COST_CHECKSUM_EN undefined: the port and the adder are absent; all other behaviour is identical.

## Structure
- Shared package jam_pkg holds:
  - N_WORKER = 8, IDX_W = 3, COST_W_DEF = 7, MAT_SIZE = 64.
  - State enum {IDLE, LOAD, RUN, DONE} as 2-bit typedef jam_srv_state_t.
- Sub-module cost_ram_8x8: 64 x COST_W storage with one synchronous write port and one synchronous read port, read-before-write. The server instantiates it once.

## Test plan
- Load beats k = 0..63 with in_data = k, then drive W = 3, J = 5 -> Cost = 29 on the next cycle. jam_rst falls the cycle after beat 63.
- Hold in_valid = 1 with in_data = 127 throughout RUN -> in_ready = 0, the memory is unchanged, and W = 0, J = 0 still returns 0.
- Pulse jam_valid in RUN -> DONE with in_ready = 1. A new beat with value 99 -> jam_rst = 1 and mem[0] = 99 while mem[1] keeps its old value.
- Assert RST after 30 beats, then load 64 beats of value 7 -> every {W, J} reads 7, and the transition to RUN follows exactly the 64th post-reset beat.
- With JAM_COST_CHECKSUM_EN, load all 127 -> checksum = 8128. Reload all 1 -> checksum = 64.
- Random in_valid gaps (50% duty) over a full load -> all 64 entries stored in order, and the LOAD -> RUN transition follows exactly the 64th handshake.
